// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse
//   Turns a raw, bouncing push-button pin into clean single-cycle events. The output is a
//   debounced level, a one-cycle press pulse and a one-cycle release pulse. The press pulse
//   can optionally repeat while the button is held.
//
// Parameters
//   DB_CYCLES      stable cycles required to accept a press or a release (>= 2)
//   REPEAT_EN      1 = emit repeat press pulses while held, 0 = one pulse per press
//   REPEAT_DELAY   cycles in the held state before the first repeat pulse (>= 1)
//   REPEAT_PERIOD  cycles between subsequent repeat pulses (>= 1)
//
// Ports
//   clk          system clock; all logic runs on the rising edge
//   reset        asynchronous, active-high reset
//   btn_raw      raw button pin; asynchronous to clk and may bounce
//   btn_level    debounced button level (1 = pressed)
//   btn_pulse    one-cycle pulse on an accepted press and on each repeat
//   btn_release  one-cycle pulse on an accepted release
module btn_debounce_pulse #(
   parameter int unsigned DB_CYCLES     = 100000,
   parameter int unsigned REPEAT_EN     = 0,
   parameter int unsigned REPEAT_DELAY  = 50000000,
   parameter int unsigned REPEAT_PERIOD = 10000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse,
   output logic btn_release
);

   localparam int unsigned CntW   = $clog2(DB_CYCLES);
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HoldW  = $clog2(RepMax + 1);

   localparam logic [CntW-1:0]  DbLast     = CntW'(DB_CYCLES - 1);
   localparam logic [HoldW-1:0] DelayLast  = HoldW'(REPEAT_DELAY - 1);
   localparam logic [HoldW-1:0] PeriodLast = HoldW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      StIdle,
      StPressWait,
      StHeld,
      StReleaseWait
   } state_e;

   state_e            state_q, state_d;
   logic              sync1_q, btn_s_q;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic              repeated_q, repeated_d;
   logic              level_q, level_d;
   logic              pulse_q, pulse_d;
   logic              release_q, release_d;
   logic [HoldW-1:0]  hold_last;

   // The first repeat waits REPEAT_DELAY; later repeats use REPEAT_PERIOD.
   assign hold_last = repeated_q ? PeriodLast : DelayLast;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      repeated_d = repeated_q;
      level_d    = level_q;
      pulse_d    = 1'b0;
      release_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            level_d = 1'b0;
            if (btn_s_q) begin
               state_d = StPressWait;
               cnt_d   = '0;
            end
         end
         StPressWait: begin
            if (!btn_s_q) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == DbLast) begin
               state_d    = StHeld;
               cnt_d      = '0;
               hold_d     = '0;
               repeated_d = 1'b0;
               level_d    = 1'b1;
               pulse_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StHeld: begin
            if (!btn_s_q) begin
               // Hold count is kept so a rejected release bounce resumes the repeat timing.
               state_d = StReleaseWait;
               cnt_d   = '0;
            end else if (REPEAT_EN != 0) begin
               if (hold_q == hold_last) begin
                  pulse_d    = 1'b1;
                  hold_d     = '0;
                  repeated_d = 1'b1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         StReleaseWait: begin
            if (btn_s_q) begin
               state_d = StHeld;
               cnt_d   = '0;
            end else if (cnt_q == DbLast) begin
               state_d    = StIdle;
               cnt_d      = '0;
               hold_d     = '0;
               repeated_d = 1'b0;
               level_d    = 1'b0;
               release_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q    <= 1'b0;
         btn_s_q    <= 1'b0;
         state_q    <= StIdle;
         cnt_q      <= '0;
         hold_q     <= '0;
         repeated_q <= 1'b0;
         level_q    <= 1'b0;
         pulse_q    <= 1'b0;
         release_q  <= 1'b0;
      end else begin
         sync1_q    <= btn_raw;
         btn_s_q    <= sync1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         repeated_q <= repeated_d;
         level_q    <= level_d;
         pulse_q    <= pulse_d;
         release_q  <= release_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_pulse   = pulse_q;
   assign btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: one instance without repeat, one with repeat, same stimulus.
module tb_btn_debounce_pulse;

   localparam int unsigned DB = 4;
   localparam int unsigned RD = 10;
   localparam int unsigned RP = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic btn_raw = 1'b0;
   logic lvl_n, pul_n, rel_n;
   logic lvl_r, pul_r, rel_r;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   btn_debounce_pulse #(
      .DB_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_n (
      .clk(clk), .reset(reset), .btn_raw(btn_raw),
      .btn_level(lvl_n), .btn_pulse(pul_n), .btn_release(rel_n)
   );

   btn_debounce_pulse #(
      .DB_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_r (
      .clk(clk), .reset(reset), .btn_raw(btn_raw),
      .btn_level(lvl_r), .btn_pulse(pul_r), .btn_release(rel_r)
   );

   typedef struct {
      logic lvl;
      logic pn;
      logic pr;
      logic rel;
   } exp_t;

   typedef struct {
      string       name;
      int          len;
      logic [63:0] raw;
      logic [63:0] lvl;
      logic [63:0] pn;
      logic [63:0] pr;
      logic [63:0] rel;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[4];

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string name);
      check1({name, " lvl_n"}, lvl_n, 1'b0);
      check1({name, " pul_n"}, pul_n, 1'b0);
      check1({name, " rel_n"}, rel_n, 1'b0);
      check1({name, " lvl_r"}, lvl_r, 1'b0);
      check1({name, " pul_r"}, pul_r, 1'b0);
      check1({name, " rel_r"}, rel_r, 1'b0);
   endtask

   // Drive one cycle of btn_raw, queue the expectation, compare after the edge.
   task automatic step(input logic raw, input exp_t e, input string tag);
      exp_t x;
      btn_raw = raw;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check1({tag, " lvl_n"}, lvl_n, x.lvl);
      check1({tag, " lvl_r"}, lvl_r, x.lvl);
      check1({tag, " pul_n"}, pul_n, x.pn);
      check1({tag, " pul_r"}, pul_r, x.pr);
      check1({tag, " rel_n"}, rel_n, x.rel);
      check1({tag, " rel_r"}, rel_r, x.rel);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      btn_raw = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   int   np = 0, nr = 0, rp_cnt = 0, rr_cnt = 0;
   bit   done = 1'b0;
   logic prev_pn = 1'b0, prev_pr = 1'b0;

   initial begin
      exp_t e;

      // Cycle k = k-th rising edge after reset release; raw high from cycle a -> pulse at a+6.
      tbl[0] = '{name: "clean", len: 40, raw: rng(2, 21), lvl: rng(8, 27), pn: rng(8, 8),
                 pr: rng(8, 8) | rng(18, 18) | rng(23, 23), rel: rng(28, 28)};
      tbl[1] = '{name: "bounce", len: 20, raw: rng(2, 2) | rng(4, 5), lvl: '0, pn: '0,
                 pr: '0, rel: '0};
      tbl[2] = '{name: "rel_bounce", len: 32, raw: rng(2, 9) | rng(12, 15), lvl: rng(8, 21),
                 pn: rng(8, 8), pr: rng(8, 8), rel: rng(22, 22)};
      tbl[3] = '{name: "repeat", len: 56, raw: rng(2, 39), lvl: rng(8, 45), pn: rng(8, 8),
                 pr: rng(8, 8) | rng(18, 18) | rng(23, 23) | rng(28, 28) | rng(33, 33)
                     | rng(38, 38),
                 rel: rng(46, 46)};

      #1 reset = 1'b1;
      #2 check_all_zero("reset_state");

      for (int s = 0; s < 4; s++) begin
         do_reset();
         for (int k = 0; k < tbl[s].len; k++) begin
            e.lvl = tbl[s].lvl[k];
            e.pn  = tbl[s].pn[k];
            e.pr  = tbl[s].pr[k];
            e.rel = tbl[s].rel[k];
            step(tbl[s].raw[k], e, $sformatf("%s c%0d", tbl[s].name, k));
         end
      end

      // Reset during PRESS_WAIT, then during HELD; press must re-debounce in full each time.
      do_reset();
      e = '{lvl: 1'b0, pn: 1'b0, pr: 1'b0, rel: 1'b0};
      for (int k = 0; k < 4; k++) step(1'b1, e, $sformatf("pw_pre c%0d", k));
      for (int r = 0; r < 2; r++) begin
         #2 reset = 1'b1;
         #1 check_all_zero(r == 0 ? "rst_in_pw" : "rst_in_held");
         @(posedge clk);
         @(negedge clk);
         reset = 1'b0;
         for (int k = 0; k < 10; k++) begin
            e.lvl = (k >= 6);
            e.pn  = (k == 6);
            e.pr  = (k == 6);
            e.rel = 1'b0;
            step(1'b1, e, $sformatf("after_rst%0d c%0d", r, k));
         end
      end

      // Asynchronous toggling at random sub-cycle offsets.
      do_reset();
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               #($urandom_range(1, 23));
               btn_raw = ~btn_raw;
               if ($urandom_range(0, 7) == 0) #($urandom_range(60, 150));
            end
            btn_raw = 1'b0;
            #400;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               check1("async no_x", $isunknown({lvl_n, pul_n, rel_n, lvl_r, pul_r, rel_r}),
                      1'b0);
               check1("async pn_width", prev_pn & pul_n, 1'b0);
               check1("async pr_width", prev_pr & pul_r, 1'b0);
               check1("async n_overlap", pul_n & rel_n, 1'b0);
               check1("async r_overlap", pul_r & rel_r, 1'b0);
               prev_pn = pul_n;
               prev_pr = pul_r;
               if (pul_n === 1'b1) np++;
               if (rel_n === 1'b1) nr++;
               if (pul_r === 1'b1) rp_cnt++;
               if (rel_r === 1'b1) rr_cnt++;
            end
         end
      join
      checks++;
      if (np != nr) begin
         errors++;
         $display("FAIL async n_counts: pulses %0d releases %0d, required equal", np, nr);
      end
      checks++;
      if (rr_cnt != nr) begin
         errors++;
         $display("FAIL async r_releases: got %0d required %0d", rr_cnt, nr);
      end
      checks++;
      if (rp_cnt < np) begin
         errors++;
         $display("FAIL async r_pulses: got %0d required at least %0d", rp_cnt, np);
      end
      check1("async end_level_n", lvl_n, 1'b0);
      check1("async end_level_r", lvl_r, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

endmodule
